// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and request-legality helpers for the
// load/store unit.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // mem_ctrl access widths
  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

  // Stores only have signed-free byte/half/word forms; loads add the unsigned pair.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == SB) || (f3 == SH) || (f3 == SW);
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

  // Width encoding 3 is never legal, so reporting it misaligned is harmless.
  function automatic logic addr_aligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      BYTE:    return 1'b1;
      HALF:    return ~lo[0];
      WORD:    return lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational sign/zero extension of the raw memory word for loads.
module load_extend
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] raw,
  output logic [WORD_SIZE-1:0] ext
);

  // Select the low byte/half/word and extend according to funct3.
  always_comb begin
    ext = '0;
    case (funct3)
      LB:      ext = {{(WORD_SIZE-8){raw[7]}}, raw[7:0]};
      LH:      ext = {{(WORD_SIZE-16){raw[15]}}, raw[15:0]};
      LW:      ext = raw;
      LBU:     ext = {{(WORD_SIZE-8){1'b0}}, raw[7:0]};
      LHU:     ext = {{(WORD_SIZE-16){1'b0}}, raw[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: IDLE accepts, ACCESS drives the
// memory port for one cycle, RESP returns the result for one cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [2:0]           req_funct3,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_write_en,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_write_data,
  output logic [1:0]           mem_ctrl,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  lsu_state_e           state_q, state_d;
  logic                 wr_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]           f3_q;
  logic                 err_q;
  logic                 req_ok;
  logic [WORD_SIZE-1:0] ext_data;

  assign req_ok = f3_legal(req_write, req_funct3) &&
                  addr_aligned(req_funct3[1:0], req_addr[1:0]);

  load_extend #(.WORD_SIZE(WORD_SIZE)) u_ext (
    .funct3 (f3_q),
    .raw    (mem_rdata),
    .ext    (ext_data)
  );

  // Next state: illegal requests skip ACCESS and go straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_ok ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus request latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          f3_q    <= req_funct3;
          err_q   <= ~req_ok;
          rdata_q <= '0;
        end
        ACCESS: rdata_q <= wr_q ? '0 : ext_data;
        default: ;
      endcase
    end
  end

  // Outputs decode from state; rst gates them so a reset landing in ACCESS
  // cannot produce a write and a reset in RESP cannot leak a response.
  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_ctrl       = BYTE;
    if (!rst) begin
      if (state_q == ACCESS) begin
        mem_write_en   = wr_q;
        mem_addr       = addr_q;
        mem_write_data = wdata_q;
        mem_ctrl       = f3_q[1:0];
      end
      if (state_q == RESP) begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads with extension, stores, errors,
// back-to-back acceptance and reset during ACCESS.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_en;
  logic [31:0] mem_addr, mem_write_data, mem_rdata;
  logic [1:0]  mem_ctrl;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [8:0] rdy_vec, rv_vec;

  load_store_unit #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Count write strobes seen at each sample point.
  always @(negedge clk) if (mem_write_en === 1'b1) we_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request in an IDLE cycle; return at the negedge after acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f);
    @(negedge clk);
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] raw, input logic [1:0] ctrl,
                         input logic [31:0] exp);
    mem_rdata = raw;
    issue(1'b0, a, 32'h0, f);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_ctrl"}, {30'd0, mem_ctrl}, {30'd0, ctrl});
    chk({tag, "_we"}, {31'd0, mem_write_en}, 32'd0);
    chk({tag, "_rv_early"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] ctrl);
    issue(1'b1, a, d, f);
    chk({tag, "_we"}, {31'd0, mem_write_en}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wdata"}, mem_write_data, d);
    chk({tag, "_ctrl"}, {30'd0, mem_ctrl}, {30'd0, ctrl});
    @(negedge clk);
    chk({tag, "_we_off"}, {31'd0, mem_write_en}, 32'd0);
    chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic w, input logic [2:0] f,
                        input logic [31:0] a);
    mem_rdata = 32'hFFFF_FFFF;
    issue(w, a, 32'hCAFE_F00D, f);
    chk({tag, "_rv"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_we"}, {31'd0, mem_write_en}, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem", {mem_write_en, mem_ctrl, mem_addr[28:0]}, 32'h0);
    chk("rst_mwd", mem_write_data, 32'h0);

    // loads
    do_load("lw",  LW,  32'h10, 32'h8899_AABB, 2'd2, 32'h8899_AABB);
    do_load("lb",  LB,  32'h21, 32'h1234_5680, 2'd0, 32'hFFFF_FF80);
    do_load("lbu", LBU, 32'h21, 32'h1234_5680, 2'd0, 32'h0000_0080);
    do_load("lh",  LH,  32'h22, 32'h7F7F_8001, 2'd1, 32'hFFFF_8001);
    do_load("lhu", LHU, 32'h22, 32'h7F7F_8001, 2'd1, 32'h0000_8001);

    // stores
    do_store("sw", SW, 32'h80, 32'hDEAD_BEEF, 2'd2);
    do_store("sh", SH, 32'h42, 32'h0000_1234, 2'd1);

    // errors: misaligned word, misaligned half, illegal funct3
    do_err("lw_mis", 1'b0, LW, 32'h13);
    do_err("sh_mis", 1'b1, SH, 32'h41);
    do_err("f3_011", 1'b0, 3'b011, 32'h0);
    @(negedge clk);
    chk("err_back_idle", {31'd0, req_ready}, 32'd1);

    // back-to-back: hold req_valid, expect ready every 3 cycles
    mem_rdata = 32'h0102_0304;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_funct3 = LW;
    rdy_vec[0] = req_ready; rv_vec[0] = resp_valid;
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      rdy_vec[i] = req_ready; rv_vec[i] = resp_valid;
    end
    req_valid = 1'b0;
    chk("b2b_ready", {23'd0, rdy_vec}, {23'd0, 9'b001_001_001});
    chk("b2b_resp", {23'd0, rv_vec}, {23'd0, 9'b100_100_100});

    // reset during ACCESS of SB
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h5; req_wdata = 32'hAB;
    req_funct3 = SB;
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc_we", {31'd0, mem_write_en}, 32'd0);
    chk("rstacc_rv", {31'd0, resp_valid}, 32'd0);
    chk("rstacc_maddr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstacc_ready", {31'd0, req_ready}, 32'd1);
    chk("rstacc_rv2", {31'd0, resp_valid}, 32'd0);
    chk("rstacc_mem", {mem_write_en, mem_ctrl, mem_addr[28:0]}, 32'h0);
    @(negedge clk);
    chk("rstacc_rv3", {31'd0, resp_valid}, 32'd0);

    // only the SW and SH stores may have strobed the write enable
    chk("we_total", we_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the single-port combined instruction/data memory. It accepts one load or store request at a time from the execute stage and drives the memory port (`write_en`, `addr`, `write_data`, `ctrl`). It captures the asynchronous read data and returns a sign- or zero-extended result, or an error flag, through a valid/ready handshake. It checks alignment and funct3 legality before touching memory, so an illegal access never writes.

## Interface
- `WORD_SIZE`, 32: data and address width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  WORD_SIZE: byte address.
- `req_wdata`  in  WORD_SIZE: store data, low bytes significant.
- `req_funct3`  in  3: RV32I load/store funct3.
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  WORD_SIZE: extended load data; 0 for stores and errors.
- `resp_err`  out  1: misaligned or illegal funct3.
- `mem_write_en`  out  1: memory write strobe.
- `mem_addr`  out  WORD_SIZE: memory byte address.
- `mem_write_data`  out  WORD_SIZE: memory write data.
- `mem_ctrl`  out  2: access width, 0 = byte, 1 = half, 2 = word.
- `mem_rdata`  in  WORD_SIZE: asynchronous little-endian read of bytes addr..addr+3.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: latch write, addr, wdata and funct3.
  - Legal and aligned → ACCESS. Otherwise → RESP with err=1.
- **ACCESS** (exactly one cycle):
  - Drive `mem_addr`=latched addr and `mem_ctrl`=funct3[1:0].
  - Drive `mem_write_data`=latched wdata.
  - `mem_write_en`=latched write.
  - For a load, register `mem_rdata` at the end of the cycle. Then → RESP.
- **RESP** (exactly one cycle): `resp_valid`=1 with the registered rdata and err. Then → IDLE. `resp_valid` is not back-pressured.
- Legal loads:
  - LB (000), LBU (100): `mem_rdata[7:0]`, sign- or zero-extended.
  - LH (001), LHU (101): `mem_rdata[15:0]`, sign- or zero-extended.
  - LW (010): all bits.
- Legal stores: SB (000), SH (001), SW (010). All other funct3 values are illegal.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
- Error responses: `resp_rdata`=0. Memory outputs stay idle: no `mem_write_en`, no ACCESS cycle.
- Outside ACCESS, all `mem_*` outputs are 0.

## Timing
- Request accepted at edge N. ACCESS occupies cycle N..N+1. `resp_valid` is high in the cycle after edge N+1.
- Throughput: one request per 3 cycles for legal accesses, one per 2 cycles for errors.
- `req_ready` is 0 in ACCESS and RESP. A request held during those states is accepted on return to IDLE.
- `mem_write_en` is high for exactly one cycle per legal store, never for loads or errors.
- Reset values:
  - State is IDLE.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - All `mem_*` outputs are 0.
- Reset asserted mid-operation (ACCESS or RESP):
  - Next cycle is IDLE.
  - `mem_write_en` is forced to 0 in the reset cycle, so no write occurs.
  - The pending response is discarded.
- Address arithmetic is not modified: `mem_addr` equals `req_addr`, and the memory performs wrap-around.

## Structure
- Package `lsu_pkg`:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - `mem_ctrl` width constants: BYTE=0, HALF=1, WORD=2.
  - State enum: IDLE, ACCESS, RESP.
- Sub-module `load_extend`: combinational; inputs funct3 and raw word, output the extended word. Used once in ACCESS before the rdata register.

## Test plan
- LW at 0x10, `mem_rdata`=0x8899AABB → `resp_rdata`=0x8899AABB, err=0, `resp_valid` 2 cycles after accept.
- LB/LBU at 0x21 with `mem_rdata`[7:0]=0x80 → 0xFFFFFF80 and 0x00000080. LH/LHU at 0x22 with [15:0]=0x8001 → 0xFFFF8001 and 0x00008001.
- SW addr 0x80, data 0xDEADBEEF → one-cycle `mem_write_en` with `mem_ctrl`=2, `mem_addr`=0x80, `mem_write_data`=0xDEADBEEF; then `resp_valid` with rdata=0.
- LW at 0x13, SH at 0x41, funct3=011 → each gives err=1 one cycle after accept, with `mem_write_en` never asserted.
- Back-to-back `req_valid` held high → `req_ready` pulses every 3 cycles, and no request is lost or duplicated.
- `rst` asserted during ACCESS of SB → no `mem_write_en`, no `resp_valid`, all outputs at reset values, IDLE next cycle.
